// File: rtl/ps2_kbd_fifo.sv
// ps2_kbd_fifo: PS/2 keyboard receiver that deserialises scan codes into a FIFO
// read by the CPU through an active-low I/O read strobe.
module ps2_kbd_fifo #(
    parameter int FIFO_AW = 3,
    parameter int TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       io_rdn,
    output logic [7:0] key_data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int PW    = FIFO_AW + 1;
    localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    state_t        state, state_next;
    logic [3:0]    bit_cnt, cnt_next;
    logic [TW-1:0] to_cnt, to_next;
    logic [7:0]    shift_reg;
    logic          parity_bit, stop_bit;
    logic          shift_en, par_en, stop_en, err_next, frame_done;

    logic clk_s1, clk_s2, clk_prev, data_s1, data_s2;
    logic fall, frame_valid;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, rd_next, wr_next;
    logic          io_rdn_q, pop_req, pop, wr_en, drop;
    logic          empty, full;
    logic [7:0]    head_next;

    // Two-flop synchronisers; clk_prev gives a one-cycle history for fall detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= ps2_data;
            data_s2  <= data_s1;
        end
    end

    assign fall        = clk_prev & ~clk_s2;
    assign frame_valid = (^shift_reg ^ parity_bit) & stop_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= 4'd0;
            to_cnt     <= '0;
            shift_reg  <= 8'h00;
            parity_bit <= 1'b0;
            stop_bit   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state     <= state_next;
            bit_cnt   <= cnt_next;
            to_cnt    <= to_next;
            frame_err <= err_next;
            if (shift_en) shift_reg  <= {data_s2, shift_reg[7:1]};
            if (par_en)   parity_bit <= data_s2;
            if (stop_en)  stop_bit   <= data_s2;
        end
    end

    // Counts 1..8 are data (LSB first), 9 is parity, 10 is stop.
    always_comb begin
        state_next = state;
        cnt_next   = bit_cnt;
        to_next    = to_cnt;
        shift_en   = 1'b0;
        par_en     = 1'b0;
        stop_en    = 1'b0;
        err_next   = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                to_next = '0;
                if (fall) begin
                    if (!data_s2) begin
                        state_next = SHIFT;
                        cnt_next   = 4'd1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (fall) begin
                    to_next  = '0;
                    cnt_next = bit_cnt + 4'd1;
                    if (bit_cnt <= 4'd8) begin
                        shift_en = 1'b1;
                    end else if (bit_cnt == 4'd9) begin
                        par_en = 1'b1;
                    end else begin
                        stop_en    = 1'b1;
                        state_next = CHECK;
                    end
                end else if (to_cnt == TO_LAST) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                    cnt_next   = 4'd0;
                    to_next    = '0;
                end else begin
                    to_next = to_cnt + TW'(1);
                end
            end
            CHECK: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
                to_next    = '0;
                frame_done = 1'b1;
                err_next   = ~frame_valid;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
                to_next    = '0;
            end
        endcase
    end

    assign pop_req = ~io_rdn_q & io_rdn;
    assign empty   = (rd_ptr == wr_ptr);
    assign full    = (rd_ptr[FIFO_AW] != wr_ptr[FIFO_AW]) &&
                     (rd_ptr[FIFO_AW-1:0] == wr_ptr[FIFO_AW-1:0]);
    assign pop     = pop_req & ~empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign wr_en   = frame_done & frame_valid & (~full | pop);
    assign drop    = frame_done & frame_valid & full & ~pop;
    assign rd_next = rd_ptr + PW'(pop);
    assign wr_next = wr_ptr + PW'(wr_en);

    // Registered head must look through to the byte being written into an empty slot.
    always_comb begin
        head_next = 8'h00;
        if (rd_next != wr_next) begin
            if (wr_en && (wr_ptr == rd_next))
                head_next = shift_reg;
            else
                head_next = mem[rd_next[FIFO_AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[FIFO_AW-1:0]] <= shift_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io_rdn_q <= 1'b1;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            key_data <= 8'h00;
            ready    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            io_rdn_q <= io_rdn;
            rd_ptr   <= rd_next;
            wr_ptr   <= wr_next;
            key_data <= head_next;
            ready    <= (rd_next != wr_next);
            if (drop)
                overflow <= 1'b1;
            else if (pop)
                overflow <= 1'b0;
        end
    end

endmodule
